// File: rtl/operand_regfile.sv
// Integer operand register file with per-register busy scoreboard.
// Define REGFILE_WB_BYPASS_EN for same-cycle write-back forwarding to the read ports.
module operand_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            waw_err,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_waw;
    logic [AW:0]     r_cnt;

    logic            w_wb;
    logic            w_rsv;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;
    logic            w_waw_nxt;

    assign w_wb  = wb_en && (wb_addr != '0);
    assign w_rsv = rsv_en && (rsv_addr != '0);

    // Reservation is applied after the clear so a same-cycle new writer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb)
            w_busy_nxt[wb_addr] = 1'b0;
        if (w_rsv)
            w_busy_nxt[rsv_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 1; i < NREG; i++)
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end

    assign w_waw_nxt = w_rsv && r_busy[rsv_addr] &&
                       !(w_wb && (wb_addr == rsv_addr));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
            r_waw  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_wb)
                r_regs[wb_addr] <= wb_data;
            r_busy <= w_busy_nxt;
            r_waw  <= w_waw_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = w_wb && (wb_addr == rs1_addr);
    assign w_fwd2 = w_wb && (wb_addr == rs2_addr);

    assign rs1_data = w_fwd1 ? wb_data : r_regs[rs1_addr];
    assign rs2_data = w_fwd2 ? wb_data : r_regs[rs2_addr];
    assign rs1_busy = !w_fwd1 && r_busy[rs1_addr];
    assign rs2_busy = !w_fwd2 && r_busy[rs2_addr];
`else
    assign rs1_data = r_regs[rs1_addr];
    assign rs2_data = r_regs[rs2_addr];
    assign rs1_busy = r_busy[rs1_addr];
    assign rs2_busy = r_busy[rs2_addr];
`endif

    assign waw_err  = r_waw;
    assign busy_cnt = r_cnt;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed self-checking bench for operand_regfile.
// Covers reset, write-back, x0, WAW, bypass and mid-flight reset.
module tb_operand_regfile;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            CLK = 1'b0;
    logic            RSTN;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic            rs1_busy;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            rs2_busy;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            waw_err;
    logic [AW:0]     busy_cnt;

    int total = 0;
    int bad   = 0;

    operand_regfile #(.XLEN(XLEN), .NREG(NREG)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .waw_err(waw_err), .busy_cnt(busy_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        rsv_en = 1'b0; rsv_addr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        RSTN = 1'b0;
        #12;
        total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL rst_rs1_data got %h exp %h", rs1_data, 32'h0); end
        total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL rst_rs2_data got %h exp %h", rs2_data, 32'h0); end
        total++; if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL rst_busy got %b exp 00", {rs1_busy, rs2_busy}); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt got %0d exp 0", busy_cnt); end
        total++; if (waw_err !== 1'b0) begin bad++; $display("FAIL rst_waw got %b exp 0", waw_err); end
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic test_basic_write();
        @(negedge CLK);
        rs1_addr = 5'd7;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL bw_cnt0 got %0d exp 0", busy_cnt); end
        tick();
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL bw_cnt1 got %0d exp 1", busy_cnt); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL bw_busy1 got %b exp 1", rs1_busy); end
        @(negedge CLK);
        idle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL bw_cnt2 got %0d exp 0", busy_cnt); end
        total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bw_data got %h exp deadbeef", rs1_data); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL bw_busy2 got %b exp 0", rs1_busy); end
    endtask

    task automatic test_x0();
        @(negedge CLK);
        rs1_addr = 5'd0;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
        #1;
        total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL x0_comb_data got %h exp 0", rs1_data); end
        tick();
        idle();
        #1;
        total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL x0_data got %h exp 0", rs1_data); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL x0_busy got %b exp 0", rs1_busy); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL x0_cnt got %0d exp 0", busy_cnt); end
        total++; if (waw_err !== 1'b0) begin bad++; $display("FAIL x0_waw got %b exp 0", waw_err); end
    endtask

    task automatic test_waw();
        @(negedge CLK);
        rs1_addr = 5'd3;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        total++; if (waw_err !== 1'b0) begin bad++; $display("FAIL waw_first got %b exp 0", waw_err); end
        @(negedge CLK);
        tick();
        total++; if (waw_err !== 1'b1) begin bad++; $display("FAIL waw_second got %b exp 1", waw_err); end
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL waw_cnt got %0d exp 1", busy_cnt); end
        @(negedge CLK);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33333333;
        tick();
        idle();
        #1;
        total++; if (waw_err !== 1'b0) begin bad++; $display("FAIL sim_waw got %b exp 0", waw_err); end
        total++; if (rs1_data !== 32'h33333333) begin bad++; $display("FAIL sim_data got %h exp 33333333", rs1_data); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL sim_busy got %b exp 1", rs1_busy); end
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL sim_cnt got %0d exp 1", busy_cnt); end
        // set x10 and clear x3 together: count stays 1
        @(negedge CLK);
        rsv_en = 1'b1; rsv_addr = 5'd10;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h3;
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL diff_cnt got %0d exp 1", busy_cnt); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL diff_busy3 got %b exp 0", rs1_busy); end
        @(negedge CLK);
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h0;
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL diff_cnt2 got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_bypass();
        @(negedge CLK);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        tick();
        @(negedge CLK);
        idle();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        total++; if (rs1_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_rs1 got %h exp a5a5a5a5", rs1_data); end
        total++; if (rs2_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_rs2 got %h exp a5a5a5a5", rs2_data); end
        total++; if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL byp_busy got %b exp 00", {rs1_busy, rs2_busy}); end
`else
        total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL byp_rs1 got %h exp 0", rs1_data); end
        total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL byp_rs2 got %h exp 0", rs2_data); end
        total++; if ({rs1_busy, rs2_busy} !== 2'b11) begin bad++; $display("FAIL byp_busy got %b exp 11", {rs1_busy, rs2_busy}); end
`endif
        tick();
        idle();
        #1;
        total++; if (rs1_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_post1 got %h exp a5a5a5a5", rs1_data); end
        total++; if (rs2_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_post2 got %h exp a5a5a5a5", rs2_data); end
        total++; if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL byp_postbusy got %b exp 00", {rs1_busy, rs2_busy}); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            idle();
            rsv_en = 1'b1; rsv_addr = AW'(i);
            if (i == 1) begin
                wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h22222222;
            end
            tick();
        end
        idle();
        rs1_addr = 5'd2; rs2_addr = 5'd4;
        #1;
        total++; if (busy_cnt !== 6'd4) begin bad++; $display("FAIL mid_cnt got %0d exp 4", busy_cnt); end
        total++; if (rs1_data !== 32'h22222222) begin bad++; $display("FAIL mid_data got %h exp 22222222", rs1_data); end
        RSTN = 1'b0;
        #1;
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL mid_rst_cnt got %0d exp 0", busy_cnt); end
        total++; if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL mid_rst_busy got %b exp 00", {rs1_busy, rs2_busy}); end
        @(negedge CLK);
        RSTN = 1'b1;
        tick();
        total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL mid_post_data got %h exp 0", rs1_data); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL mid_post_cnt got %0d exp 0", busy_cnt); end
        total++; if (waw_err !== 1'b0) begin bad++; $display("FAIL mid_post_waw got %b exp 0", waw_err); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_x0();
        test_waw();
        test_bypass();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
- Parametrised integer operand register file for the RV32I core: XLEN-wide, NREG-deep, two combinational read ports, one synchronous write-back port.
- Adds a per-register busy scoreboard: set when decode issues an instruction with a destination, cleared on write-back.
- Issue logic uses the busy flags to detect RAW hazards.
- Sits between decode/issue and the ALU/LSU write-back path.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers, including x0. Must be a power of 2 and at least 2.
- AW, $clog2(NREG), register address width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs1_data  out  XLEN  read port 1 data.
- rs1_busy  out  1  register at rs1_addr has a pending write.
- rs2_addr  in  AW  read port 2 address.
- rs2_data  out  XLEN  read port 2 data.
- rs2_busy  out  1  register at rs2_addr has a pending write.
- rsv_en  in  1  reserve a destination, issued by decode.
- rsv_addr  in  AW  destination being reserved.
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back destination.
- wb_data  in  XLEN  write-back data.
- waw_err  out  1  registered flag: the previous cycle reserved a register that was already busy.
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
Clock and reset:
- One clock (CLK); reset is asynchronous, active-low (RSTN).
- On RSTN low: all registers cleared to 0, all busy bits 0, waw_err 0, busy_cnt 0.
- Reset mid-operation discards all pending reservations; the next cycle is clean.

Register x0:
- Always reads 0 and is never busy.
- wb_en or rsv_en with address 0 has no effect on any state.
- Address 0 never contributes to waw_err or busy_cnt.

Write-back:
- On rising CLK with wb_en and wb_addr != 0: reg[wb_addr] <= wb_data, busy[wb_addr] <= 0, unless overridden by a same-cycle reservation (see below).
- Write-back to a non-busy register is legal; data is written and busy stays 0.

Reservation:
- On rising CLK with rsv_en and rsv_addr != 0: busy[rsv_addr] <= 1.
- If that bit is already 1 and not being cleared by wb this cycle, waw_err <= 1 for exactly one cycle; otherwise waw_err <= 0.

Simultaneous events:
- wb and rsv to the same nonzero address in one cycle: data is written AND busy ends at 1 (new writer wins); waw_err 0.
- wb and rsv to different addresses: both take effect.

Reads:
- Reads are combinational from current state, zero-cycle latency.
- rsN_data = reg[rsN_addr]; rsN_busy = busy[rsN_addr].
- Both ports may address the same register; both return identical values.

busy_cnt:
- Registered population count of busy[NREG-1:1].
- Updates one cycle after the set/clear.
- A simultaneous set and clear of different registers leaves the count unchanged.
- Never exceeds NREG-1.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: combinational write-through forwarding. When wb_en and wb_addr == rsN_addr != 0:
  - rsN_data = wb_data in the same cycle;
  - rsN_busy = 0 in the same cycle, regardless of the stored busy bit.
  - Both ports forward independently.
- Not defined: reads return only stored state. The value and busy clear become visible the cycle after write-back.

Test Plan:
1. Reset then read: pulse RSTN low with rs1_addr=5, rs2_addr=31 → rs1_data=0, rs2_data=0, both busy 0, busy_cnt 0.
2. Basic write: rsv x7; next cycle wb x7=0xDEADBEEF; one cycle later rs1_addr=7 → data 0xDEADBEEF, rs1_busy 0.
   - busy_cnt sequence: 0, then 1 after the reserve edge, then 0 after the write-back edge.
3. x0 immunity: rsv_en with rsv_addr=0 and wb_en with wb_addr=0, wb_data=0x12345678 → rs1_addr=0 reads 0, busy 0, busy_cnt 0, waw_err 0.
4. WAW and simultaneous events:
   - rsv x3 twice on consecutive cycles → waw_err=1 for one cycle after the second edge; busy_cnt=1.
   - Then wb x3 and rsv x3 in the same cycle → data updated, rs1_busy stays 1, waw_err 0.
5. Bypass: wb x9=0xA5A5A5A5 with rs1_addr=rs2_addr=9 in the same cycle.
   - With REGFILE_WB_BYPASS_EN: both ports read 0xA5A5A5A5 and busy 0 combinationally.
   - Without the macro: old value until the next cycle.
6. Reset mid-flight: reserve x1..x4, assert RSTN low between clock edges → busy_cnt 0 and all busy 0 immediately; registers 0 after release.
